// File: rtl/register_bank.sv
// rtl/register_bank.sv - multi-register storage with LOAD/INC/DEC/CLR write port, two registered read ports
// Reads and flags are all registered, so no combinational path exists from any input to any output.
module register_bank #(
  parameter int SIZE     = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter int BYPASS   = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [1:0]        WrMode,
  input  logic [SIZE-1:0]   WrData,
  input  logic [ADDR_W-1:0] RdAddrA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [SIZE-1:0]   RdDataA,
  output logic [SIZE-1:0]   RdDataB,
  output logic              ZeroFlag,
  output logic              CarryFlag
);

  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_DEC  = 2'b10;

  logic [SIZE-1:0] regs_q [NUM_REGS];
  logic [SIZE-1:0] regs_d [NUM_REGS];
  logic [SIZE-1:0] rd_a_q, rd_a_d;
  logic [SIZE-1:0] rd_b_q, rd_b_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;

  logic            wr_hit;
  logic [SIZE-1:0] wr_cur;
  logic [SIZE-1:0] wr_nv;
  logic            wr_carry;
  logic [SIZE-1:0] rd_a_cur, rd_b_cur;
  logic            rd_a_fwd, rd_b_fwd;

  // Address decode; out-of-range addresses never match, so reads of them return 0.
  always_comb begin
    wr_hit   = 1'b0;
    wr_cur   = '0;
    rd_a_cur = '0;
    rd_b_cur = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (WrAddr == i[ADDR_W-1:0]) begin
        wr_hit = WrEn;
        wr_cur = regs_q[i];
      end
      if (RdAddrA == i[ADDR_W-1:0]) rd_a_cur = regs_q[i];
      if (RdAddrB == i[ADDR_W-1:0]) rd_b_cur = regs_q[i];
    end
  end

  always_comb begin
    wr_nv    = '0;
    wr_carry = 1'b0;
    case (WrMode)
      MODE_LOAD: wr_nv = WrData;
      MODE_INC: begin
        wr_nv    = wr_cur + SIZE'(1);
        wr_carry = (wr_cur == '1);
      end
      MODE_DEC: begin
        wr_nv    = wr_cur - SIZE'(1);
        wr_carry = (wr_cur == '0);
      end
      default: wr_nv = '0;
    endcase
  end

  always_comb begin
    regs_d  = regs_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_hit && (WrAddr == i[ADDR_W-1:0])) regs_d[i] = wr_nv;
    end
    if (wr_hit) begin
      zero_d  = (wr_nv == '0);
      carry_d = wr_carry;
    end
  end

  // Forwarding only applies when the read address actually hits the register being written.
  always_comb begin
    rd_a_fwd = (BYPASS != 0) && wr_hit && (RdAddrA == WrAddr);
    rd_b_fwd = (BYPASS != 0) && wr_hit && (RdAddrB == WrAddr);
    rd_a_d   = rd_a_fwd ? wr_nv : rd_a_cur;
    rd_b_d   = rd_b_fwd ? wr_nv : rd_b_cur;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (Enable) begin
      regs_q  <= regs_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign RdDataA   = rd_a_q;
  assign RdDataB   = rd_b_q;
  assign ZeroFlag  = zero_q;
  assign CarryFlag = carry_q;

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - directed self-checking bench for register_bank
// Three instances share stimulus: default (bypass, 4 regs), no-bypass, and 3 registers.
module tb_register_bank;

  logic       Clock = 1'b0;
  logic       Reset, Enable, WrEn;
  logic [1:0] WrAddr, WrMode, RdAddrA, RdAddrB;
  logic [7:0] WrData;

  logic [7:0] a_byp, b_byp, a_nob, b_nob, a_r3, b_r3;
  logic       z_byp, c_byp, z_nob, c_nob, z_r3, c_r3;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  register_bank #(.SIZE(8), .NUM_REGS(4), .ADDR_W(2), .BYPASS(1)) u_byp (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrMode(WrMode), .WrData(WrData), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
    .RdDataA(a_byp), .RdDataB(b_byp), .ZeroFlag(z_byp), .CarryFlag(c_byp));

  register_bank #(.SIZE(8), .NUM_REGS(4), .ADDR_W(2), .BYPASS(0)) u_nob (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrMode(WrMode), .WrData(WrData), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
    .RdDataA(a_nob), .RdDataB(b_nob), .ZeroFlag(z_nob), .CarryFlag(c_nob));

  register_bank #(.SIZE(8), .NUM_REGS(3), .ADDR_W(2), .BYPASS(1)) u_r3 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrMode(WrMode), .WrData(WrData), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
    .RdDataA(a_r3), .RdDataB(b_r3), .ZeroFlag(z_r3), .CarryFlag(c_r3));

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] addr, input logic [1:0] mode,
                       input logic [7:0] data, input logic [1:0] ra, input logic [1:0] rb);
    WrEn = we; WrAddr = addr; WrMode = mode; WrData = data; RdAddrA = ra; RdAddrB = rb;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Enable = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd0);
    step(); step();
    checks++; if (a_byp !== 8'h00) begin failures++; $display("FAIL reset_rda got %h exp 00", a_byp); end
    checks++; if (b_byp !== 8'h00) begin failures++; $display("FAIL reset_rdb got %h exp 00", b_byp); end
    checks++; if ({z_byp, c_byp} !== 2'b00) begin failures++; $display("FAIL reset_flags got %b exp 00", {z_byp, c_byp}); end
    Reset = 1'b0; Enable = 1'b1;
  endtask

  task automatic test_load_read();
    drive(1'b1, 2'd2, 2'b00, 8'hA5, 2'd0, 2'd1); step();
    checks++; if ({z_byp, c_byp} !== 2'b00) begin failures++; $display("FAIL load_flags got %b exp 00", {z_byp, c_byp}); end
    drive(1'b0, 2'd0, 2'b00, 8'h00, 2'd2, 2'd0); step();
    checks++; if (a_byp !== 8'hA5) begin failures++; $display("FAIL load_rda got %h exp a5", a_byp); end
    checks++; if (b_byp !== 8'h00) begin failures++; $display("FAIL load_r0 got %h exp 00", b_byp); end
    drive(1'b0, 2'd0, 2'b00, 8'h00, 2'd1, 2'd3); step();
    checks++; if (a_byp !== 8'h00) begin failures++; $display("FAIL load_r1 got %h exp 00", a_byp); end
    checks++; if (b_byp !== 8'h00) begin failures++; $display("FAIL load_r3 got %h exp 00", b_byp); end
  endtask

  task automatic test_inc_dec();
    drive(1'b1, 2'd1, 2'b00, 8'hFF, 2'd1, 2'd1); step();
    checks++; if ({a_byp, z_byp, c_byp} !== {8'hFF, 2'b00}) begin failures++; $display("FAIL ld_ff got %h/%b exp ff/00", a_byp, {z_byp, c_byp}); end
    drive(1'b1, 2'd1, 2'b01, 8'h00, 2'd1, 2'd1); step();
    checks++; if ({a_byp, z_byp, c_byp} !== {8'h00, 2'b11}) begin failures++; $display("FAIL inc_wrap got %h/%b exp 00/11", a_byp, {z_byp, c_byp}); end
    drive(1'b1, 2'd1, 2'b10, 8'h00, 2'd1, 2'd1); step();
    checks++; if ({a_byp, z_byp, c_byp} !== {8'hFF, 2'b01}) begin failures++; $display("FAIL dec_borrow got %h/%b exp ff/01", a_byp, {z_byp, c_byp}); end
    drive(1'b1, 2'd1, 2'b01, 8'h00, 2'd1, 2'd1); step();
    checks++; if ({a_byp, z_byp, c_byp} !== {8'h00, 2'b11}) begin failures++; $display("FAIL inc_wrap2 got %h/%b exp 00/11", a_byp, {z_byp, c_byp}); end
    drive(1'b1, 2'd1, 2'b00, 8'h05, 2'd1, 2'd1); step();
    checks++; if ({z_byp, c_byp} !== 2'b00) begin failures++; $display("FAIL ld5_flags got %b exp 00", {z_byp, c_byp}); end
    drive(1'b1, 2'd1, 2'b01, 8'h00, 2'd1, 2'd1); step(); step();
    checks++; if ({a_byp, z_byp, c_byp} !== {8'h07, 2'b00}) begin failures++; $display("FAIL inc_b2b got %h/%b exp 07/00", a_byp, {z_byp, c_byp}); end
    drive(1'b1, 2'd1, 2'b10, 8'h00, 2'd1, 2'd1); step();
    checks++; if ({a_byp, z_byp, c_byp} !== {8'h06, 2'b00}) begin failures++; $display("FAIL dec_plain got %h/%b exp 06/00", a_byp, {z_byp, c_byp}); end
    drive(1'b1, 2'd1, 2'b11, 8'h9C, 2'd1, 2'd1); step();
    checks++; if ({a_byp, z_byp, c_byp} !== {8'h00, 2'b10}) begin failures++; $display("FAIL clr got %h/%b exp 00/10", a_byp, {z_byp, c_byp}); end
  endtask

  task automatic test_bypass();
    Reset = 1'b1; drive(1'b0, 2'd0, 2'b00, 8'h00, 2'd0, 2'd0); step(); Reset = 1'b0;
    drive(1'b1, 2'd3, 2'b00, 8'h3C, 2'd3, 2'd0); step();
    checks++; if (a_byp !== 8'h3C) begin failures++; $display("FAIL bypass_on got %h exp 3c", a_byp); end
    checks++; if (a_nob !== 8'h00) begin failures++; $display("FAIL bypass_off got %h exp 00", a_nob); end
    drive(1'b0, 2'd0, 2'b00, 8'h00, 2'd3, 2'd3); step();
    checks++; if (a_nob !== 8'h3C) begin failures++; $display("FAIL bypass_off_next got %h exp 3c", a_nob); end
  endtask

  task automatic test_enable();
    drive(1'b1, 2'd2, 2'b11, 8'h00, 2'd3, 2'd3); step();
    checks++; if ({a_byp, b_byp, z_byp, c_byp} !== {8'h3C, 8'h3C, 2'b10}) begin failures++; $display("FAIL en_setup got %h %h %b exp 3c 3c 10", a_byp, b_byp, {z_byp, c_byp}); end
    Enable = 1'b0;
    drive(1'b1, 2'd0, 2'b00, 8'h11, 2'd0, 2'd0); step(); step();
    checks++; if ({a_byp, b_byp, z_byp, c_byp} !== {8'h3C, 8'h3C, 2'b10}) begin failures++; $display("FAIL en_low_hold got %h %h %b exp 3c 3c 10", a_byp, b_byp, {z_byp, c_byp}); end
    Enable = 1'b1; step();
    checks++; if ({a_byp, b_byp, z_byp} !== {8'h11, 8'h11, 1'b0}) begin failures++; $display("FAIL en_high_commit got %h %h %b exp 11 11 0", a_byp, b_byp, z_byp); end
    checks++; if (a_nob !== 8'h00) begin failures++; $display("FAIL en_nob_old got %h exp 00", a_nob); end
    drive(1'b0, 2'd0, 2'b00, 8'h00, 2'd0, 2'd0); step();
    checks++; if (a_nob !== 8'h11) begin failures++; $display("FAIL en_nob_new got %h exp 11", a_nob); end
  endtask

  task automatic test_out_of_range();
    Reset = 1'b1; drive(1'b0, 2'd0, 2'b00, 8'h00, 2'd0, 2'd0); step(); Reset = 1'b0;
    drive(1'b1, 2'd0, 2'b00, 8'hFF, 2'd0, 2'd0); step();
    drive(1'b1, 2'd0, 2'b01, 8'h00, 2'd0, 2'd0); step();
    checks++; if ({z_r3, c_r3} !== 2'b11) begin failures++; $display("FAIL oor_setup got %b exp 11", {z_r3, c_r3}); end
    drive(1'b1, 2'd3, 2'b00, 8'h77, 2'd0, 2'd3); step();
    checks++; if ({z_r3, c_r3} !== 2'b11) begin failures++; $display("FAIL oor_flags_hold got %b exp 11", {z_r3, c_r3}); end
    checks++; if ({a_r3, b_r3} !== 16'h0000) begin failures++; $display("FAIL oor_reads got %h %h exp 00 00", a_r3, b_r3); end
    checks++; if ({b_byp, z_byp, c_byp} !== {8'h77, 2'b00}) begin failures++; $display("FAIL oor_4reg_commit got %h %b exp 77 00", b_byp, {z_byp, c_byp}); end
    drive(1'b0, 2'd0, 2'b00, 8'h00, 2'd3, 2'd0); step();
    checks++; if ({a_r3, b_r3} !== 16'h0000) begin failures++; $display("FAIL oor_reread got %h %h exp 00 00", a_r3, b_r3); end
  endtask

  task automatic test_reset_midwrite();
    drive(1'b1, 2'd0, 2'b00, 8'h10, 2'd0, 2'd1); step();
    drive(1'b1, 2'd1, 2'b00, 8'h20, 2'd0, 2'd1); step();
    checks++; if ({a_byp, b_byp} !== 16'h1020) begin failures++; $display("FAIL rst_setup got %h %h exp 10 20", a_byp, b_byp); end
    Reset = 1'b1;
    drive(1'b1, 2'd0, 2'b11, 8'h00, 2'd0, 2'd1); step();
    checks++; if ({a_byp, b_byp, z_byp, c_byp} !== {16'h0000, 2'b00}) begin failures++; $display("FAIL rst_mid got %h %h %b exp 00 00 00", a_byp, b_byp, {z_byp, c_byp}); end
    Reset = 1'b0;
    drive(1'b0, 2'd0, 2'b00, 8'h00, 2'd0, 2'd0); step();
    checks++; if ({a_byp, b_byp} !== 16'h0000) begin failures++; $display("FAIL rst_r0 got %h %h exp 00 00", a_byp, b_byp); end
    drive(1'b0, 2'd0, 2'b00, 8'h00, 2'd1, 2'd1); step();
    checks++; if ({a_byp, b_byp} !== 16'h0000) begin failures++; $display("FAIL rst_r1 got %h %h exp 00 00", a_byp, b_byp); end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_inc_dec();
    test_bypass();
    test_enable();
    test_out_of_range();
    test_reset_midwrite();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
